// File: rtl/step_sequencer_if.sv
// Control/status bundle between the step sequencer and the 3-bit light-state generator side.
// The master drives requests and generator feedback; the slave is the sequencer.
interface step_sequencer_if;
  logic       mode_req;
  logic       mode_req_vld;
  logic       hold;
  logic [2:0] state_in;
  logic       step;
  logic       mode;
  logic       pending;
  logic       err;

  modport master (
    output mode_req,
    output mode_req_vld,
    output hold,
    output state_in,
    input  step,
    input  mode,
    input  pending,
    input  err
  );

  modport slave (
    input  mode_req,
    input  mode_req_vld,
    input  hold,
    input  state_in,
    output step,
    output mode,
    output pending,
    output err
  );
endinterface

// File: rtl/step_sequencer.sv
// Paces the 3-bit light-state generator: second prescaler, per-state dwell, step pulse,
// direction control applied only at the safe state, and a sticky feedback checker.
module step_sequencer #(
  parameter int DIV         = 4,
  parameter int DWELL_LONG  = 3,
  parameter int DWELL_SHORT = 1,
  parameter int CW          = 4
) (
  input  logic             clk,
  input  logic             CR,
  step_sequencer_if.slave  bus
);

  localparam int            PW         = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(DWELL_LONG - 1);
  localparam logic [CW-1:0] SHORT_LAST = CW'(DWELL_SHORT - 1);
  localparam logic [2:0]    SAFE_STATE = 3'b110;

  typedef enum logic [2:0] {
    ST_000 = 3'b000,
    ST_001 = 3'b001,
    ST_010 = 3'b010,
    ST_011 = 3'b011,
    ST_100 = 3'b100,
    ST_101 = 3'b101,
    ST_110 = 3'b110,
    ST_111 = 3'b111
  } gen_state_e;

  function automatic gen_state_e predict_next(input gen_state_e cur, input logic fwd);
    gen_state_e nxt;
    case (cur)
      ST_111:  nxt = ST_000;
      ST_000:  nxt = ST_110;
      ST_110:  nxt = fwd ? ST_100 : ST_010;
      ST_100:  nxt = fwd ? ST_101 : ST_110;
      ST_101:  nxt = fwd ? ST_001 : ST_100;
      ST_001:  nxt = fwd ? ST_011 : ST_101;
      ST_011:  nxt = fwd ? ST_010 : ST_001;
      ST_010:  nxt = fwd ? ST_110 : ST_011;
      default: nxt = ST_111;
    endcase
    return nxt;
  endfunction

  function automatic logic is_long_state(input logic [2:0] s);
    logic long_v;
    case (s)
      3'b011, 3'b101, 3'b110: long_v = 1'b1;
      default:                long_v = 1'b0;
    endcase
    return long_v;
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic          step_q, step_d;
  logic          mode_q, mode_d;
  logic          pending_q, pending_d;
  logic          req_q, req_d;
  logic          apply_dly_q, apply_dly_d;
  logic          chk_q, chk_d;
  logic          err_q, err_d;
  gen_state_e    pred_q, pred_d;

  logic          sec_tick_s;
  logic          expiry_s;
  logic          apply_s;
  logic [CW-1:0] dwell_last_s;

  // A held sequencer keeps both counters frozen, so an expiry masked by hold reappears later.
  always_comb begin
    presc_d      = presc_q;
    dwell_d      = dwell_q;
    sec_tick_s   = (presc_q == PRESC_LAST) && !bus.hold;
    dwell_last_s = is_long_state(bus.state_in) ? LONG_LAST : SHORT_LAST;
    expiry_s     = sec_tick_s && (dwell_q == dwell_last_s);
    if (bus.hold) begin
      presc_d = presc_q;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (expiry_s) begin
      dwell_d = '0;
    end else if (sec_tick_s) begin
      dwell_d = dwell_q + CW'(1);
    end else begin
      dwell_d = dwell_q;
    end
  end

  // A fresh strobe always beats an apply in the same cycle; an apply delays step by one cycle
  // so the generator sees the new direction settled before it advances.
  always_comb begin
    req_d       = req_q;
    pending_d   = pending_q;
    mode_d      = mode_q;
    apply_s     = expiry_s && (bus.state_in == SAFE_STATE) && pending_q && !bus.mode_req_vld;
    apply_dly_d = apply_s;
    step_d      = (expiry_s && !apply_s) || apply_dly_q;
    if (bus.mode_req_vld) begin
      if (bus.mode_req != mode_q) begin
        req_d     = bus.mode_req;
        pending_d = 1'b1;
      end else begin
        pending_d = 1'b0;
      end
    end else if (apply_s) begin
      mode_d    = req_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Feedback is compared in the cycle after step, once the generator has advanced.
  always_comb begin
    pred_d = pred_q;
    chk_d  = step_q;
    err_d  = err_q;
    if (step_q) begin
      pred_d = predict_next(pred_q, mode_q);
    end else begin
      pred_d = pred_q;
    end
    if (chk_q && (bus.state_in != pred_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk or posedge CR) begin
    if (CR) begin
      presc_q     <= '0;
      dwell_q     <= '0;
      step_q      <= 1'b0;
      mode_q      <= 1'b1;
      pending_q   <= 1'b0;
      req_q       <= 1'b1;
      apply_dly_q <= 1'b0;
      chk_q       <= 1'b0;
      err_q       <= 1'b0;
      pred_q      <= ST_111;
    end else begin
      presc_q     <= presc_d;
      dwell_q     <= dwell_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      req_q       <= req_d;
      apply_dly_q <= apply_dly_d;
      chk_q       <= chk_d;
      err_q       <= err_d;
      pred_q      <= pred_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.mode    = mode_q;
  assign bus.pending = pending_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with an attached generator model and a step scoreboard
// holding the cycle and direction of every step the stimulus should provoke.
module tb_step_sequencer;

  logic clk;
  logic CR;
  step_sequencer_if bus ();

  step_sequencer #(.DIV(4), .DWELL_LONG(3), .DWELL_SHORT(1), .CW(4)) dut (
    .clk (clk),
    .CR  (CR),
    .bus (bus)
  );

  typedef struct {
    int   cyc;
    logic mode;
  } exp_t;

  exp_t       q[$];
  int         cyc;
  int         n_cmp;
  int         n_fail;
  logic [2:0] gen;
  logic       force_en;
  logic [2:0] force_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference generator: ring order for forward, reverse walks the ring backwards.
  function automatic logic [2:0] gen_next(input logic [2:0] s, input logic fwd);
    logic [2:0] ring [6];
    logic [2:0] r;
    ring = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
    r = s;
    if (s == 3'b111) r = 3'b000;
    else if (s == 3'b000) r = 3'b110;
    else begin
      for (int i = 0; i < 6; i++) begin
        if (ring[i] == s) r = fwd ? ring[(i + 1) % 6] : ring[(i + 5) % 6];
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge CR) begin
    if (CR) gen <= 3'b111;
    else if (bus.step === 1'b1) gen <= gen_next(gen, bus.mode);
  end

  always @(posedge clk or posedge CR) begin
    if (CR) cyc <= 1;
    else cyc <= cyc + 1;
  end

  assign bus.state_in = force_en ? force_val : gen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic m);
    exp_t e;
    e.cyc  = c;
    e.mode = m;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (bus.step === 1'b1) begin
      chk("step_expected", (q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("step_cycle", e.cyc, cyc);
        chk("step_mode", bus.mode, e.mode);
      end
    end
  endtask

  task automatic run_to(input int k);
    int guard;
    guard = 0;
    while (cyc < k && guard < 1000) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    CR           = 1'b1;
    force_en     = 1'b0;
    force_val    = 3'b000;
    bus.mode_req = 1'b1;
    bus.mode_req_vld = 1'b0;
    bus.hold     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_step", bus.step, 1'b0);
    chk("rst_mode", bus.mode, 1'b1);
    chk("rst_pending", bus.pending, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    CR = 1'b0;

    // Basic pacing plus a cancelled request inside the first 110 dwell.
    push(5, 1'b1); push(9, 1'b1); push(21, 1'b1);
    run_to(6);  chk("state_000", bus.state_in, 3'b000);
    run_to(10); chk("state_110", bus.state_in, 3'b110);
    run_to(13); bus.mode_req = 1'b0; bus.mode_req_vld = 1'b1;
    run_to(14); bus.mode_req_vld = 1'b0; chk("cancel_pend_set", bus.pending, 1'b1);
    run_to(15); bus.mode_req = 1'b1; bus.mode_req_vld = 1'b1;
    run_to(16); bus.mode_req_vld = 1'b0; chk("cancel_pend_clr", bus.pending, 1'b0);
    run_to(22); chk("state_100", bus.state_in, 3'b100);
    chk("cancel_mode", bus.mode, 1'b1);
    chk("q_empty_1", q.size(), 0);

    // Reverse request in 101, applied at the 110 expiry (cycle 68) with step delayed to 70.
    push(25, 1'b1); push(37, 1'b1); push(41, 1'b1); push(53, 1'b1); push(57, 1'b1);
    push(70, 1'b0);
    run_to(30); chk("state_101", bus.state_in, 3'b101);
    bus.mode_req = 1'b0; bus.mode_req_vld = 1'b1;
    run_to(31); bus.mode_req_vld = 1'b0; chk("req_pend", bus.pending, 1'b1);
    run_to(68); chk("pend_wait", bus.pending, 1'b1); chk("mode_wait", bus.mode, 1'b1);
    run_to(69); chk("apply_pend", bus.pending, 1'b0); chk("apply_mode", bus.mode, 1'b0);
    chk("apply_step_low", bus.step, 1'b0);
    run_to(71); chk("rev_state_010", bus.state_in, 3'b010); chk("err_ok", bus.err, 1'b0);

    // Hold for ten cycles inside the 011 dwell: step moves from 85 to 95.
    push(73, 1'b0); push(95, 1'b0);
    run_to(74); chk("state_011", bus.state_in, 3'b011);
    run_to(78); bus.hold = 1'b1;
    run_to(88); bus.hold = 1'b0;

    // Feedback fault right after the step that predicts 001.
    run_to(96); chk("q_empty_2", q.size(), 0); chk("state_001", bus.state_in, 3'b001);
    chk("err_before", bus.err, 1'b0);
    force_val = 3'b111; force_en = 1'b1;
    run_to(97); force_en = 1'b0; chk("err_set", bus.err, 1'b1);

    push(99, 1'b0);
    run_to(102); bus.mode_req = 1'b1; bus.mode_req_vld = 1'b1;
    run_to(103); bus.mode_req_vld = 1'b0; chk("pend_before_rst", bus.pending, 1'b1);
    run_to(104); chk("err_sticky", bus.err, 1'b1); chk("q_empty_3", q.size(), 0);

    // Asynchronous reset between edges during the long 101 dwell.
    CR = 1'b1;
    #1;
    chk("arst_step", bus.step, 1'b0);
    chk("arst_mode", bus.mode, 1'b1);
    chk("arst_pending", bus.pending, 1'b0);
    chk("arst_err", bus.err, 1'b0);
    #2;
    CR = 1'b0;
    push(5, 1'b1);
    run_to(6); chk("post_rst_000", bus.state_in, 3'b000); chk("post_rst_err", bus.err, 1'b0);
    run_to(8);
    chk("q_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
- Timing and mode controller for the 3-bit light-state generator.
- Divides the system clock into second ticks and holds each generator state for a programmable dwell.
- Issues a one-cycle step pulse that advances the generator, and drives its direction input M.
- Accepts direction-change requests but applies them only at the safe state 3'b110. Checks generator feedback and flags a sticky error on mismatch.

Parameters:
- DIV, 4, clk cycles per second tick; at least 2. Use 4 in simulation and the board crystal frequency in hardware.
- DWELL_LONG, 3, seconds held in two-bit-set states 011, 101, 110; at least 1.
- DWELL_SHORT, 1, seconds held in states 000, 001, 010, 100, 111; at least 1.
- CW, 4, width of the dwell counter; must hold max(DWELL_LONG, DWELL_SHORT).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- CR  input  1  asynchronous, active-high reset.
- mode_req  input  1  requested direction (1 = forward, 0 = reverse).
- mode_req_vld  input  1  one-cycle strobe; captures mode_req.
- hold  input  1  level; freezes sequencing while high.
- state_in  input  3  current generator state (feedback).
- step  output  1  registered one-cycle advance pulse to the generator.
- mode  output  1  registered direction to the generator M input.
- pending  output  1  a mode request is waiting for the safe point.
- err  output  1  sticky feedback mismatch.

Behaviour:
- Reset (CR high, asynchronous):
  - Outputs: step=0, mode=1, pending=0, err=0.
  - Internal: prescaler=0, dwell counter=0, predicted state=111.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - sec_tick is true in the cycle where the count equals DIV-1 and hold=0.
  - While hold=1 the prescaler and dwell counter freeze and no expiry occurs.
  - It is not cleared by step.
- Dwell selection: the dwell is chosen from state_in (DWELL_LONG or DWELL_SHORT, as above).
- Expiry:
  - Occurs on a sec_tick when the dwell counter equals dwell-1; otherwise a sec_tick increments the counter.
  - On expiry the dwell counter clears to 0.
  - At the cycle after expiry step=1 for exactly one cycle, so latency is one cycle.
- Mode capture:
  - mode_req_vld=1 with mode_req different from mode loads the request register and sets pending=1.
  - A strobe with mode_req equal to mode clears pending.
  - The latest strobe wins.
- Mode apply:
  - Applied only on an expiry while state_in==110 and pending=1.
  - On that edge: mode takes the requested value and pending clears.
  - step rises one edge later, so M is stable for one full cycle before the generator's edge.
  - A strobe arriving in the same cycle as an apply overrides it: the new request is stored and the apply does not happen.
- Predicted next state on each step:
  - From 111 or 000: next is 000 and 110 respectively, in both modes.
  - mode=1 sequence: 110→100→101→001→011→010→110.
  - mode=0 sequence: 110→010→011→001→101→100→110.
  - The prediction uses the mode value at the step cycle.
- Check: two cycles after step, if state_in differs from the prediction then err=1. err clears only on CR.
- Reset mid-dwell: all progress is lost; the sequence restarts from predicted state 111 with a short dwell.
- hold asserted in the same cycle as an expiry: the expiry is suppressed and is reissued after hold drops and the next sec_tick occurs.

Test Plan:
- Basic pacing. Setup: DIV=4, LONG=3, SHORT=1, generator model attached; release CR.
  - Required: step pulses at post-reset cycles 5 and 9; then 12-cycle gaps in 110.
  - Required state_in sequence: 111→000→110→100.
- Mode change at the safe point. Stimulus: in state 101, strobe mode_req=0.
  - Required: pending=1 until the 110 expiry.
  - Required: mode falls one cycle before step; the next state is 010, not 100.
- Request cancel. Stimulus: strobe 0, then strobe 1, while mode=1.
  - Required: pending returns to 0 and mode stays 1 through 110.
- Hold. Stimulus: assert hold for 10 cycles mid-dwell in 011.
  - Required: no step during hold; the 011 dwell is extended by exactly 10 cycles.
- Error detection. Stimulus: force state_in=111 after a step that predicts 001.
  - Required: err=1 two cycles after the step, and err stays 1 until CR.
- Asynchronous reset. Stimulus: pulse CR mid-cycle between clock edges during a long dwell.
  - Required: outputs return immediately to mode=1, step=0, pending=0, err=0.
  - Required: the next step comes 5 cycles after release.
